// File: rtl/tohost_monitor.sv
// Test-run supervisor: holds the CPU in reset, then watches CSR writes to the
// tohost address and records pass/fail/timeout with a RUN-cycle count.
module tohost_monitor #(
  parameter int unsigned  RESET_HOLD_CYCLES = 30,
  parameter int unsigned  TIMEOUT_CYCLES    = 10000,
  parameter logic [11:0]  TOHOST_ADDR       = 12'h51e
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [30:0] fail_code,
  output logic [31:0] cycle_count
);

  localparam logic [31:0] HOLD_LAST = 32'(RESET_HOLD_CYCLES - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]  sync_q;
  logic        cpu_rst_q, cpu_rst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        timeout_q, timeout_d;
  logic [30:0] fail_code_q, fail_code_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic        complete;

  assign complete = csr_we && (csr_addr == TOHOST_ADDR) && csr_wdata[0];

  // Reset release is only trusted once it has passed through two flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b00;
    else      sync_q <= {sync_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_HOLD;
      hold_cnt_q    <= '0;
      cpu_rst_q     <= 1'b1;
      busy_q        <= 1'b1;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      timeout_q     <= 1'b0;
      fail_code_q   <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      cpu_rst_q     <= cpu_rst_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      timeout_q     <= timeout_d;
      fail_code_q   <= fail_code_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    cpu_rst_d     = cpu_rst_q;
    busy_d        = busy_q;
    done_d        = done_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    timeout_d     = timeout_q;
    fail_code_d   = fail_code_q;
    cycle_count_d = cycle_count_q;

    if (start) begin
      state_d     = S_HOLD;
      hold_cnt_d  = '0;
      cpu_rst_d   = 1'b1;
      busy_d      = 1'b1;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      fail_d      = 1'b0;
      timeout_d   = 1'b0;
      fail_code_d = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            // Counter parks at its last value until the reset sync catches up.
            if (sync_q[1]) begin
              state_d       = S_RUN;
              cpu_rst_d     = 1'b0;
              cycle_count_d = '0;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 32'd1;
          end
        end
        S_RUN: begin
          if (complete) begin
            state_d     = S_DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            pass_d      = (csr_wdata[31:1] == 31'd0);
            fail_d      = (csr_wdata[31:1] != 31'd0);
            fail_code_d = csr_wdata[31:1];
          end else if (cycle_count_q == TO_LAST) begin
            state_d     = S_DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            timeout_d   = 1'b1;
            fail_code_d = '0;
          end else begin
            cycle_count_d = cycle_count_q + 32'd1;
          end
        end
        S_DONE: begin
        end
        default: begin
          state_d    = S_HOLD;
          hold_cnt_d = '0;
          cpu_rst_d  = 1'b1;
          busy_d     = 1'b1;
        end
      endcase
    end
  end

  assign cpu_rst     = cpu_rst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign fail_code   = fail_code_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed bench for tohost_monitor: reset/hold timing, pass/fail/timeout,
// ignored writes, start priority and asynchronous mid-run reset.
module tb_tohost_monitor;

  logic        clk;
  logic        rst;
  logic        start;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic [30:0] fail_code;
  logic [31:0] cycle_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n;

  tohost_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .csr_we     (csr_we),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .timeout    (timeout),
    .fail_code  (fail_code),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_we    = 1'b1;
    csr_addr  = addr;
    csr_wdata = data;
    $display("write addr=0x%03h data=0x%08h at cycle_count=%0d", addr, data, cycle_count);
    tick(1);
    csr_we    = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
  endtask

  // Edges seen until cpu_rst drops, bounded.
  task automatic hold_len(output int edges);
    edges = 0;
    while (cpu_rst && edges < 200) begin
      tick(1);
      edges++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".cpu_rst"}, 64'(cpu_rst), 64'd1);
    check_eq({tag, ".busy"}, 64'(busy), 64'd1);
    check_eq({tag, ".flags"}, 64'({done, pass, fail, timeout}), 64'd0);
    check_eq({tag, ".fail_code"}, 64'(fail_code), 64'd0);
    check_eq({tag, ".cycle_count"}, 64'(cycle_count), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;

    // Asynchronous assertion, checked before any rising edge sees it.
    #12 rst = 1'b0;
    #1 check_reset_outputs("por");
    tick(3);
    @(negedge clk) rst = 1'b1;
    hold_len(n);
    check_eq("por.hold_len", 64'(n), 64'd30);
    check_eq("por.busy_run", 64'(busy), 64'd1);

    // No writes at all: timeout after 10000 RUN cycles.
    n = 0;
    while (!done && n < 20000) begin
      tick(1);
      n++;
    end
    check_eq("to.run_len", 64'(n), 64'd10000);
    check_eq("to.flags", 64'({done, pass, fail, timeout}), 64'b1001);
    check_eq("to.cycle_count", 64'(cycle_count), 64'd9999);
    check_eq("to.busy_cpurst", 64'({busy, cpu_rst}), 64'd0);
    check_eq("to.fail_code", 64'(fail_code), 64'd0);

    // Restart from DONE.
    pulse_start();
    check_eq("st.flags", 64'({done, pass, fail, timeout}), 64'd0);
    check_eq("st.busy_cpurst", 64'({busy, cpu_rst}), 64'b11);
    hold_len(n);
    check_eq("st.hold_len", 64'(n), 64'd30);

    // Pass at cycle 50.
    tick(50);
    check_eq("p.cycle_pre", 64'(cycle_count), 64'd50);
    csr_write(12'h51e, 32'h1);
    check_eq("p.flags", 64'({done, pass, fail, timeout}), 64'b1100);
    check_eq("p.fail_code", 64'(fail_code), 64'd0);
    check_eq("p.busy_cpurst", 64'({busy, cpu_rst}), 64'd0);
    tick(5);
    check_eq("p.cycle_frozen", 64'(cycle_count), 64'd50);

    // Fail with code 5, later writes in DONE ignored.
    pulse_start();
    hold_len(n);
    check_eq("f.hold_len", 64'(n), 64'd30);
    tick(3);
    csr_write(12'h51e, 32'h0000_000B);
    check_eq("f.flags", 64'({done, pass, fail, timeout}), 64'b1010);
    check_eq("f.fail_code", 64'(fail_code), 64'd5);
    check_eq("f.cycle", 64'(cycle_count), 64'd3);
    csr_write(12'h51e, 32'h1);
    check_eq("f.flags_after", 64'({done, pass, fail, timeout}), 64'b1010);
    check_eq("f.code_after", 64'(fail_code), 64'd5);

    // Ignored writes, then completion on the timeout cycle.
    pulse_start();
    hold_len(n);
    tick(10);
    csr_write(12'h51e, 32'h2);
    check_eq("ig.even", 64'({busy, done}), 64'b10);
    csr_write(12'h340, 32'h1);
    check_eq("ig.other", 64'({busy, done}), 64'b10);
    check_eq("ig.cycle", 64'(cycle_count), 64'd12);
    tick(9999 - 12);
    check_eq("lw.cycle_pre", 64'(cycle_count), 64'd9999);
    csr_write(12'h51e, 32'h1);
    check_eq("lw.flags", 64'({done, pass, fail, timeout}), 64'b1100);
    check_eq("lw.cycle", 64'(cycle_count), 64'd9999);

    // Start beats a same-cycle completing write; writes in HOLD ignored.
    pulse_start();
    hold_len(n);
    tick(2);
    start = 1'b1; csr_we = 1'b1; csr_addr = 12'h51e; csr_wdata = 32'h1;
    tick(1);
    start = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
    check_eq("pri.flags", 64'({done, pass, fail, timeout}), 64'd0);
    check_eq("pri.cpu_rst", 64'(cpu_rst), 64'd1);
    csr_write(12'h51e, 32'h3);
    check_eq("hw.flags", 64'({done, pass, fail, timeout}), 64'd0);
    hold_len(n);
    check_eq("hw.hold_rest", 64'(n), 64'd29);

    // Asynchronous reset at RUN cycle 100.
    tick(100);
    check_eq("ar.cycle_pre", 64'(cycle_count), 64'd100);
    #2 rst = 1'b0;
    #1 check_reset_outputs("ar");
    tick(4);
    @(negedge clk) rst = 1'b1;
    hold_len(n);
    check_eq("ar.hold_len", 64'(n), 64'd30);
    csr_write(12'h51e, 32'h1);
    check_eq("ar.flags", 64'({done, pass, fail, timeout}), 64'b1100);
    check_eq("ar.cycle", 64'(cycle_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tohost_monitor.md
TOHOST_MONITOR -- requirements
Module: tohost_monitor

Interface
REQ-001 SHALL have parameter RESET_HOLD_CYCLES, default 30: number of cycles cpu_rst is held after each (re)start.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 10000: number of RUN cycles allowed before timeout.
REQ-003 SHALL have parameter TOHOST_ADDR, default 12'h51e: CSR address that is monitored.
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-low.
REQ-006 start  in  1  single-cycle pulse that restarts a test run.
REQ-007 csr_we  in  1  CSR write strobe from the CPU.
REQ-008 csr_addr  in  12  CSR write address.
REQ-009 csr_wdata  in  32  CSR write data.
REQ-010 cpu_rst  out  1  active-high reset driven to the CPU.
REQ-011 busy  out  1  high in HOLD or RUN.
REQ-012 done  out  1  sticky; test finished (pass, fail or timeout).
REQ-013 pass  out  1  sticky; tohost reported success.
REQ-014 fail  out  1  sticky; tohost reported a non-zero code.
REQ-015 timeout  out  1  sticky; no tohost completion within TIMEOUT_CYCLES.
REQ-016 fail_code  out  31  latched csr_wdata[31:1] from the completing write.
REQ-017 cycle_count  out  32  number of RUN cycles elapsed.

Function
REQ-018 SHALL implement the FSM states HOLD, RUN and DONE, with all outputs registered.
REQ-019 HOLD: cpu_rst=1, busy=1; the hold counter increments each cycle; on the cycle the count equals RESET_HOLD_CYCLES-1, the FSM goes to RUN and clears cycle_count.
REQ-020 In HOLD, cpu_rst SHALL be high for exactly RESET_HOLD_CYCLES clock edges.
REQ-021 RUN: cpu_rst=0, busy=1; cycle_count increments by 1 each cycle.
REQ-022 RUN: a completing write is csr_we=1, csr_addr==TOHOST_ADDR and csr_wdata[0]=1; it SHALL move the FSM to DONE on that edge.
REQ-023 On a completing write, pass=1 if csr_wdata[31:1]==0, else fail=1; fail_code=csr_wdata[31:1] in both cases.
REQ-024 RUN: a write to TOHOST_ADDR with csr_wdata[0]=0, or a write to any other address, SHALL be ignored.
REQ-025 RUN: when cycle_count==TIMEOUT_CYCLES-1 and no completing write is present, the FSM SHALL go to DONE with timeout=1 and fail_code=0.
REQ-026 A completing write and the timeout condition in the same cycle SHALL resolve as the write (pass/fail), never timeout.
REQ-027 DONE: done=1, busy=0, cpu_rst=0; cycle_count frozen; flags and fail_code held; CSR writes ignored.
REQ-028 Exactly one of pass/fail/timeout SHALL be high whenever done=1; all three SHALL be low whenever done=0.
REQ-029 start=1 in any state SHALL move the FSM to HOLD on the next edge, clearing done, pass, fail, timeout, fail_code and the hold counter.
REQ-030 start SHALL take priority over a same-cycle completing write or timeout.
REQ-031 CSR writes in HOLD SHALL be ignored.
REQ-032 cycle_count SHALL be 32-bit unsigned and cannot wrap, because TIMEOUT_CYCLES < 2^32 bounds it.

Reset
REQ-033 rst=0 SHALL immediately force state=HOLD, hold counter=0, cpu_rst=1, busy=1, done=0, pass=0, fail=0, timeout=0, fail_code=0, cycle_count=0.
REQ-034 Reset asserted mid-RUN or in DONE SHALL discard all results; after release, the block starts a fresh HOLD of RESET_HOLD_CYCLES.
REQ-035 Reset release SHALL be synchronized internally (two-flop) before the FSM leaves HOLD.

Verification
REQ-036 Release rst, no CSR writes -> cpu_rst high 30 cycles then low; timeout=1, done=1 after 10000 RUN cycles; cycle_count=9999.
REQ-037 In RUN, write 0x51e data 32'h1 at cycle 50 -> pass=1, fail_code=0, cycle_count=50 frozen, cpu_rst=0.
REQ-038 In RUN, write 0x51e data 32'h0000_000B -> fail=1, fail_code=5; then write 0x51e data 32'h1 -> no change.
REQ-039 In RUN, write 0x51e data 32'h2 and write 0x340 data 32'h1 -> ignored, busy stays 1; write 0x51e data 32'h1 at cycle 9999 -> pass=1, timeout=0.
REQ-040 start pulse in DONE -> flags clear next cycle, cpu_rst high 30 cycles, new run completes normally.
REQ-041 rst asserted at RUN cycle 100 -> all outputs at reset values asynchronously; after release, full HOLD repeats.
